// File: rtl/mem_bus_responder.sv
// ---------------------------------------------------------------------------
// mem_bus_responder
//
// Byte-wide responder on the RAM side of the memory controller. It serves
// controller reads and writes to a synchronous single-port RAM and decodes
// the IO region (addr[17:16] == 2'b11). Bytes stored to the UART data
// address are queued in a TX FIFO that drains to a UART transmitter through
// a paced valid/ready handshake. The FIFO level produces the io_buffer_full
// back-pressure that the controller checks before every IO store.
//
// Ports:
//   clk             system clock
//   rst_in          asynchronous active-low reset
//   rdy_in          global ready; RAM access and FIFO pushes pause when low
//   mem_rw          1 = write this cycle, 0 = read
//   mem_aout[31:0]  byte address (bits 17:0 decoded)
//   mem_dout[7:0]   write data from controller
//   mem_din[7:0]    registered read data to controller
//   io_buffer_full  TX FIFO holds FIFO_DEPTH-1 or more bytes
//   uart_tx_valid   uart_tx_data holds a byte to send
//   uart_tx_data    byte at the FIFO head
//   uart_tx_ready   UART accepts the byte this cycle
//   tx_overflow     sticky: a push was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module mem_bus_responder #(
  parameter int ADDR_BITS  = 17,
  parameter int FIFO_DEPTH = 8,
  parameter int TX_DIVIDE  = 4
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        mem_rw,
  input  logic [31:0] mem_aout,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  output logic        tx_overflow
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int PACE_W    = (TX_DIVIDE > 1) ? $clog2(TX_DIVIDE) : 1;
  localparam int RAM_WORDS = 1 << ADDR_BITS;

  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ALMOST  = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(TX_DIVIDE - 1);

  // Low address bits that select a register inside the IO region.
  localparam logic [2:0] IO_UART_DATA = 3'd0;
  localparam logic [2:0] IO_UART_STAT = 3'd4;

  // Which register currently drives mem_din. SRC_NONE covers the interval
  // between reset and the first read, where mem_din must read as zero.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_IO   = 2'd2
  } rd_src_e;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic                 w_is_io;
  logic                 w_rd_cycle;
  logic                 w_ram_wr;
  logic                 w_ram_rd;
  logic                 w_push_req;
  logic [ADDR_BITS-1:0] w_ram_addr;
  logic                 w_unused;

  assign w_is_io    = (mem_aout[17:16] == 2'b11);
  assign w_rd_cycle = rdy_in && !mem_rw;
  assign w_ram_wr   = rdy_in && mem_rw && !w_is_io;
  assign w_ram_rd   = w_rd_cycle && !w_is_io;
  assign w_push_req = rdy_in && mem_rw && w_is_io && (mem_aout[2:0] == IO_UART_DATA);
  assign w_ram_addr = mem_aout[ADDR_BITS-1:0];

  // Upper address bits are outside the decoded window.
  assign w_unused = ^mem_aout[31:18];

  // -------------------------------------------------------------------------
  // RAM: single port, registered read with read enable so the output holds
  // across write cycles and rdy_in-low cycles.
  // -------------------------------------------------------------------------
  logic [7:0] r_ram [RAM_WORDS];
  logic [7:0] r_ram_q;

  // NOTE: the RAM array and its read register carry no reset; a reset port
  // would stop the array mapping onto a block RAM. The reset-visible value
  // of mem_din comes from r_src instead.
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      r_ram[w_ram_addr] <= mem_dout;
    end
    if (w_ram_rd) begin
      r_ram_q <= r_ram[w_ram_addr];
    end
  end

  // -------------------------------------------------------------------------
  // TX FIFO state
  // -------------------------------------------------------------------------
  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PACE_W-1:0] r_pace;
  logic              r_overflow;

  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_pop;
  logic w_push;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_FULL);

  // The head is only offered once the pacing counter has run out.
  assign uart_tx_valid = !w_fifo_empty && (r_pace == '0);
  assign uart_tx_data  = r_fifo[r_rd_ptr];
  assign w_pop         = uart_tx_valid && uart_tx_ready;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push = w_push_req && (!w_fifo_full || w_pop);

  // One slot of margin: the controller samples this flag an edge before its
  // store lands, so the flag must rise while one slot is still free.
  assign io_buffer_full = (r_count >= CNT_ALMOST);
  assign tx_overflow    = r_overflow;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= 8'h00;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pace     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_dout;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      // Push and pop together leave the count unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end

      // Pacing runs from the UART side and ignores rdy_in.
      if (w_pop) begin
        r_pace <= PACE_RELOAD;
      end else if (r_pace != '0) begin
        r_pace <= r_pace - PACE_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read data path
  // -------------------------------------------------------------------------
  rd_src_e    r_src;
  logic [7:0] r_io_q;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_src  <= SRC_NONE;
      r_io_q <= 8'h00;
    end else if (w_rd_cycle) begin
      if (w_is_io) begin
        r_src  <= SRC_IO;
        r_io_q <= (mem_aout[2:0] == IO_UART_STAT) ? {7'b0, w_fifo_empty} : 8'h00;
      end else begin
        r_src  <= SRC_RAM;
      end
    end
  end

  // NOTE: combinational outputs get a default before the case so that no
  // path through the block leaves mem_din unassigned and infers a latch.
  always_comb begin
    mem_din = 8'h00;
    case (r_src)
      SRC_RAM: mem_din = r_ram_q;
      SRC_IO:  mem_din = r_io_q;
      default: mem_din = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_responder
//
// Stimulus drives one bus cycle per clock and, for every cycle, pushes the
// expected visible state (mem_din, TX handshake, flags) into a scoreboard
// queue. A monitor on the falling edge pops and compares. The reference
// model is a byte array for RAM plus a queue for the TX FIFO, with pacing
// expressed as "cycles since the last pop".
// ---------------------------------------------------------------------------
module tb_mem_bus_responder;

  localparam int ADDR_BITS  = 17;
  localparam int FIFO_DEPTH = 8;
  localparam int TX_DIVIDE  = 4;
  localparam int RAM_WORDS  = 1 << ADDR_BITS;

  localparam logic [31:0] IO_DATA = 32'h0003_0000;
  localparam logic [31:0] IO_STAT = 32'h0003_0004;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        mem_rw = 1'b0;
  logic [31:0] mem_aout = '0;
  logic [7:0]  mem_dout = '0;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        tx_overflow;

  mem_bus_responder #(
    .ADDR_BITS (ADDR_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TX_DIVIDE (TX_DIVIDE)
  ) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .mem_rw        (mem_rw),
    .mem_aout      (mem_aout),
    .mem_dout      (mem_dout),
    .mem_din       (mem_din),
    .io_buffer_full(io_buffer_full),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready),
    .tx_overflow   (tx_overflow)
  );

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Scoreboard and checking
  // -------------------------------------------------------------------------
  typedef struct {
    logic [7:0] din;
    logic       valid;
    logic       full;
    logic       ovf;
    logic [7:0] head;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  logic [7:0] ram_m [RAM_WORDS];
  logic [7:0] fifo_m[$];
  logic [7:0] din_m;
  logic       ovf_m;
  int         cyc_m;
  int         last_pop_m;

  function automatic void model_reset();
    fifo_m.delete();
    din_m      = 8'h00;
    ovf_m      = 1'b0;
    last_pop_m = -1000;
  endfunction

  // One bus cycle: drive inputs for the next edge, record what the outputs
  // must show during this cycle, then advance the model across that edge.
  task automatic cycle(input logic rdy, input logic rw, input logic [31:0] addr,
                       input logic [7:0] data, input logic ready);
    exp_t                 e;
    logic                 valid;
    logic                 pop;
    logic                 io;
    logic                 push_req;
    logic                 accept;
    logic [ADDR_BITS-1:0] ra;
    @(posedge clk);
    #1;
    rdy_in        = rdy;
    mem_rw        = rw;
    mem_aout      = addr;
    mem_dout      = data;
    uart_tx_ready = ready;

    valid   = (fifo_m.size() != 0) && (cyc_m - last_pop_m >= TX_DIVIDE);
    e.din   = din_m;
    e.valid = valid;
    e.full  = (fifo_m.size() >= FIFO_DEPTH - 1);
    e.ovf   = ovf_m;
    e.head  = valid ? fifo_m[0] : 8'h00;
    exp_q.push_back(e);

    pop      = valid && ready;
    io       = (addr[17:16] == 2'b11);
    ra       = addr[ADDR_BITS-1:0];
    push_req = rdy && rw && io && (addr[2:0] == 3'd0);
    accept   = push_req && ((fifo_m.size() < FIFO_DEPTH) || pop);

    if (rdy && !rw) begin
      if (io) din_m = (addr[2:0] == 3'd4) ? 8'(fifo_m.size() == 0) : 8'h00;
      else    din_m = ram_m[ra];
    end
    if (rdy && rw && !io) ram_m[ra] = data;
    if (push_req && !accept) ovf_m = 1'b1;
    if (pop) begin
      void'(fifo_m.pop_front());
      last_pop_m = cyc_m;
    end
    if (accept) fifo_m.push_back(data);
    cyc_m++;
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 8'h00, ready);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] data, input logic ready);
    cycle(1'b1, 1'b1, addr, data, ready);
  endtask

  task automatic rd(input logic [31:0] addr, input logic ready);
    cycle(1'b1, 1'b0, addr, 8'h00, ready);
  endtask

  task automatic push(input logic [7:0] data, input logic ready);
    cycle(1'b1, 1'b1, IO_DATA, data, ready);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_in = 1'b0;
    #1;
    check("reset uart_tx_valid", uart_tx_valid, 0);
    check("reset io_buffer_full", io_buffer_full, 0);
    check("reset tx_overflow", tx_overflow, 0);
    check("reset uart_tx_data", uart_tx_data, 0);
    check("reset mem_din", mem_din, 0);
    rdy_in        = 1'b0;
    mem_rw        = 1'b0;
    uart_tx_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b1;
  endtask

  // Monitor: compare every cycle's outputs against the scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_in && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("mem_din", mem_din, e.din);
      check("uart_tx_valid", uart_tx_valid, e.valid);
      check("io_buffer_full", io_buffer_full, e.full);
      check("tx_overflow", tx_overflow, e.ovf);
      if (e.valid) check("uart_tx_data", uart_tx_data, e.head);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [31:0] a;
    int          k;

    for (int i = 0; i < RAM_WORDS; i++) begin
      ram_m[i]     = 8'(i) ^ 8'h5A;
      dut.r_ram[i] = 8'(i) ^ 8'h5A;
    end
    ram_m[17'h00011]     = 8'h3C;
    dut.r_ram[17'h00011] = 8'h3C;
    model_reset();
    cyc_m = 0;

    #3;
    check("por mem_din", mem_din, 0);
    check("por uart_tx_valid", uart_tx_valid, 0);
    check("por uart_tx_data", uart_tx_data, 0);
    check("por io_buffer_full", io_buffer_full, 0);
    check("por tx_overflow", tx_overflow, 0);
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b1;

    // RAM write then read-back, plus a preloaded location.
    wr(32'h0001_0, 8'hA5, 1'b0);
    rd(32'h0001_0, 1'b0);
    rd(32'h0001_1, 1'b0);
    @(negedge clk);
    check("ram readback 0x10", mem_din, 8'hA5);
    idle(1, 1'b0);
    @(negedge clk);
    check("ram preload 0x11", mem_din, 8'h3C);

    // Two bytes drained with pacing.
    push(8'h48, 1'b1);
    push(8'h69, 1'b1);
    idle(12, 1'b1);

    // Back-pressure and overflow.
    for (int i = 0; i < 7; i++) push(8'h80 + 8'(i), 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    check("almost full after 7", io_buffer_full, 1);
    push(8'h87, 1'b0);
    push(8'hEE, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    check("overflow after 9th", tx_overflow, 1);
    idle(FIFO_DEPTH * TX_DIVIDE + 8, 1'b1);

    // Simultaneous push/pop around count 3 and pointer wrap, 20 bytes.
    for (int i = 0; i < 3; i++) push(8'h10 + 8'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      push(8'h20 + 8'(i), 1'b1);
      idle(TX_DIVIDE - 1, 1'b1);
    end
    idle(FIFO_DEPTH * TX_DIVIDE + 8, 1'b1);

    // rdy_in low: RAM write and push suppressed, queued byte still drains.
    push(8'hC3, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0020, 8'h77, 1'b1);
    cycle(1'b0, 1'b1, IO_DATA, 8'h55, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0000_0020, 8'h00, 1'b1);
    rd(32'h0000_0020, 1'b1);
    rd(IO_STAT, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3: a = 32'($urandom_range(0, 63));
        4, 5, 6:    a = IO_DATA;
        7:          a = IO_STAT;
        8:          a = IO_DATA + 32'($urandom_range(1, 7));
        default:    a = 32'h0001_FFC0 + 32'($urandom_range(0, 63));
      endcase
      cycle($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), a,
            8'($urandom), $urandom_range(0, 3) != 0);
    end
    idle(FIFO_DEPTH * TX_DIVIDE + 8, 1'b1);

    // Reset mid-drain with three bytes still queued.
    for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i), 1'b0);
    idle(1, 1'b1);
    @(negedge clk);
    check("pre-reset valid", uart_tx_valid, 1);
    async_reset();
    rd(IO_STAT, 1'b1);
    idle(1, 1'b1);
    @(negedge clk);
    check("status after reset", mem_din, 8'h01);

    push(8'h5E, 1'b1);
    push(8'hF0, 1'b1);
    idle(4 * TX_DIVIDE, 1'b1);

    @(negedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 0);
    check("final uart_tx_valid", uart_tx_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Byte-wide memory-bus responder sitting on the far side of the memory controller's RAM port. It serves controller reads and writes to a synchronous single-port RAM and decodes the IO region (`addr[17:16] == 2'b11`). Bytes written to the UART data address go into a TX FIFO, which drains to a UART transmitter through a paced valid/ready handshake. It generates the `io_buffer_full` back-pressure that the controller checks before every IO store.

## Interface
Parameters:
- `ADDR_BITS`, 17: RAM is 2^ADDR_BITS bytes, indexed by `mem_aout[ADDR_BITS-1:0]`.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, at least 4.
- `TX_DIVIDE`, 4: minimum cycles from one TX pop to the next; at least 1.

Ports:
- `clk`  in  1  system clock.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global ready; responder is paused when low.
- `mem_rw`  in  1  1 = write this cycle, 0 = read.
- `mem_aout`  in  32  byte address from controller; bits 17:0 used.
- `mem_dout`  in  8  write data from controller.
- `mem_din`  out  8  read data to controller.
- `io_buffer_full`  out  1  TX FIFO almost full; controller must not issue IO stores.
- `uart_tx_valid`  out  1  `uart_tx_data` holds a byte to send.
- `uart_tx_data`  out  8  byte at the FIFO head.
- `uart_tx_ready`  in  1  UART accepts the byte this cycle.
- `tx_overflow`  out  1  sticky: a push was dropped because the FIFO was full.

## Operation
- Region decode: IO when `mem_aout[17:16] == 2'b11`, otherwise RAM.
- RAM write: `mem_rw = 1` and RAM region -> `ram[mem_aout[ADDR_BITS-1:0]] <= mem_dout`.
- RAM read: every cycle with `mem_rw = 0`, `mem_din <=` RAM byte at the address. This is a registered read.
- IO write to `0x30000` (`addr[2:0] == 0`): push `mem_dout` into the TX FIFO.
  - If the FIFO is full, drop the byte and set `tx_overflow`.
  - IO writes to other IO addresses are ignored.
- IO read:
  - `0x30004` returns `{7'b0, fifo_empty}`.
  - Every other IO address returns `8'h00`.
- A write cycle leaves `mem_din` unchanged.
- TX FIFO:
  - Circular buffer with wrap-around read/write pointers and a count register of width log2(FIFO_DEPTH)+1.
  - `uart_tx_valid = (count != 0) && (pace_cnt == 0)`.
  - `uart_tx_data = fifo[rd_ptr]`.
- Pop on `uart_tx_valid && uart_tx_ready`. On each pop, `pace_cnt` loads `TX_DIVIDE-1` and decrements to 0 on each following cycle.
- Push and pop in the same cycle: both pointers advance and count is unchanged. A push is accepted while full only if a pop occurs in that same cycle.
- `io_buffer_full = (count >= FIFO_DEPTH-1)`, driven combinationally from the count register.
  - This keeps one slot of margin, because the controller samples the flag one edge before its write lands.
- `rdy_in` low:
  - RAM and FIFO pushes are suppressed and `mem_din` holds.
  - The TX drain and `pace_cnt` continue, since the UART side is independent.
- RAM contents are not reset. The simulation preload mechanism is owned by the testbench.

## Timing
- Reset (`rst_in = 0`, asynchronous) drives:
  - `mem_din = 0`, `uart_tx_valid = 0`, `uart_tx_data = 0` (FIFO storage cleared), `io_buffer_full = 0`, `tx_overflow = 0`.
  - Pointers, count and `pace_cnt` all 0.
- Reset mid-drain discards all queued bytes. `uart_tx_valid` falls immediately.
- Read latency is 1 cycle: address A sampled at edge N gives `ram[A]` on `mem_din` after edge N.
- Write takes effect at the sampling edge. A read of the same address at the next edge returns the new byte.
- Push at edge N: count increments after N. `uart_tx_valid` can rise after edge N when the FIFO was empty and `pace_cnt = 0`.
- Back-to-back pops occur at most every `TX_DIVIDE` cycles. With `TX_DIVIDE = 1`, one pop per cycle is possible.
- `io_buffer_full` rises in the cycle after the push that brings count to `FIFO_DEPTH-1`. It falls in the cycle after the pop that brings count below that value.

## Test plan
- RAM write/read: write `0xA5` to `0x00010`, then read `0x00010` -> `mem_din = 0xA5` one cycle after the read address is presented. A read of `0x00011` (unwritten, preloaded `0x3C`) -> `0x3C`.
- IO push/drain: with `uart_tx_ready = 1` and `TX_DIVIDE = 4`, write `0x48` then `0x69` to `0x30000` -> `uart_tx_data` shows `0x48` then `0x69`, with pops exactly 4 cycles apart.
- Back-pressure: hold `uart_tx_ready = 0` and push 7 bytes (`FIFO_DEPTH = 8`) -> `io_buffer_full = 1` after the 7th push. An 8th push is accepted. A 9th push sets `tx_overflow` and that byte is never sent.
- Simultaneous push and pop while count = 3 -> count stays 3 and FIFO order is preserved across pointer wrap. Run 20 bytes through to exercise wrap.
- `rdy_in` low: a write to `0x00020` and a push to `0x30000` issued during the low period -> RAM unchanged and no FIFO entry. An already-queued byte still drains.
- Async reset asserted mid-drain with 3 bytes queued -> `uart_tx_valid = 0` immediately and count = 0. After release, a read of `0x30004` -> `0x01`.
